tdm_demux: RTL

- Receive end of the team's time-division multiplexed link: takes a serial stream of WIDTH-bit slots, SLOTS slots per frame, with a frame-sync marker on slot 0.
- Distributes each slot to its own channel output; the sending side is the existing 2:1 / N:1 mux path.
- Captures into a shadow buffer and updates all channel outputs together once per complete frame.
- Tracks frame alignment with a HUNT/LOCKED state machine and flags sync errors.

---
 rtl/tdm_demux.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/tdm_demux.sv
/*==============================================================================
 * Module   : tdm_demux
 * Function : TDM link receiver. Hunts for frame sync, collects SLOTS slots of
 *            WIDTH bits into a shadow buffer and publishes the whole frame at
 *            once. Optional macro TDM_DEMUX_FRAME_CNT_EN adds an 8-bit
 *            frame counter output.
 * Revision : 1.0  initial release
 *============================================================================*/
`default_nettype none

module tdm_demux #(
    parameter int WIDTH = 1,
    parameter int SLOTS = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         din,
    input  logic                     din_valid,
    input  logic                     frame_sync,
    output logic [SLOTS*WIDTH-1:0]   dout,
    output logic                     frame_valid,
    output logic                     locked,
`ifdef TDM_DEMUX_FRAME_CNT_EN
    output logic                     sync_err,
    output logic [7:0]               frame_cnt
`else
    output logic                     sync_err
`endif
);

    localparam int            C_CW   = $clog2(SLOTS);
    localparam logic [C_CW-1:0] C_LAST = C_CW'(SLOTS - 1);

    typedef enum logic [0:0] {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [C_CW-1:0]          r_cnt;
    logic [C_CW-1:0]          w_cnt_next;
    logic [C_CW-1:0]          w_wr_idx;
    logic [SLOTS*WIDTH-1:0]   r_shadow;
    logic [SLOTS*WIDTH-1:0]   w_shadow_next;
    logic [SLOTS*WIDTH-1:0]   r_dout;
    logic                     r_frame_valid;
    logic                     r_sync_err;
    logic                     w_wr_en;
    logic                     w_wr_slot0;
    logic                     w_frame_done;
    logic                     w_err;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_wr_en      = 1'b0;
        w_wr_slot0   = 1'b0;
        w_frame_done = 1'b0;
        w_err        = 1'b0;
        if (din_valid) begin
            case (r_state)
                ST_HUNT: begin
                    if (frame_sync) begin
                        w_wr_en      = 1'b1;
                        w_wr_slot0   = 1'b1;
                        w_cnt_next   = C_CW'(1);
                        w_state_next = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (frame_sync) begin
                        // An early sync restarts the frame; the partial one is dropped
                        w_wr_en    = 1'b1;
                        w_wr_slot0 = 1'b1;
                        w_cnt_next = C_CW'(1);
                        w_err      = (r_cnt != '0);
                    end else if (r_cnt == '0) begin
                        w_err        = 1'b1;
                        w_state_next = ST_HUNT;
                    end else begin
                        w_wr_en = 1'b1;
                        if (r_cnt == C_LAST) begin
                            w_frame_done = 1'b1;
                            w_cnt_next   = '0;
                        end else begin
                            w_cnt_next = r_cnt + C_CW'(1);
                        end
                    end
                end
                default: w_state_next = ST_HUNT;
            endcase
        end
    end

    assign w_wr_idx = w_wr_slot0 ? '0 : r_cnt;

    // Shadow image including the current beat, so the last slot reaches dout in the same edge
    for (genvar k = 0; k < SLOTS; k++) begin : g_slot
        assign w_shadow_next[k*WIDTH +: WIDTH] =
            (w_wr_en && (w_wr_idx == C_CW'(k))) ? din : r_shadow[k*WIDTH +: WIDTH];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_HUNT;
            r_cnt         <= '0;
            r_shadow      <= '0;
            r_dout        <= '0;
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_cnt         <= w_cnt_next;
            r_shadow      <= w_shadow_next;
            if (w_frame_done) begin
                r_dout <= w_shadow_next;
            end
            r_frame_valid <= w_frame_done;
            r_sync_err    <= w_err;
        end
    end

    assign dout        = r_dout;
    assign frame_valid = r_frame_valid;
    assign locked      = (r_state == ST_LOCKED);
    assign sync_err    = r_sync_err;

`ifdef TDM_DEMUX_FRAME_CNT_EN
    logic [7:0] r_frame_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_cnt <= 8'd0;
        end else if (w_frame_done) begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`endif

endmodule

`default_nettype wire
